// File: rtl/rv_mcop_ctl.sv
// Multi-cycle ALU op controller: launches two-cycle multiplies and iterative
// divide/sqrt ops, stalls dependent instructions and strobes the late writeback.
module rv_mcop_ctl #(
    parameter int DIV_TMO = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rdy,
    input  logic       iss_vld,
    input  logic [1:0] iss_kind,
    input  logic [4:0] iss_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       cmpl,
    output logic       start,
    output logic       stall,
    output logic       wb_we,
    output logic [4:0] wb_rd,
    output logic       busy,
    output logic       tmo_err
);

    localparam int CW = $clog2(DIV_TMO + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ITER = 2'd2
    } state_t;

    state_t         state_reg;
    logic [4:0]     prd_reg;
    logic [CW-1:0]  cnt_reg;
    logic           cmpl_pend_reg;
    logic           wb_we_reg;
    logic [4:0]     wb_rd_reg;
    logic           tmo_err_reg;

    logic           in_iter;
    logic           prd_nz;
    logic           is_multi;
    logic           stall_struct;
    logic           haz_raw;
    logic           haz_waw;
    logic           accept;
    logic           acc_mul;
    logic           acc_iter;
    logic           done;
    logic [CW-1:0]  cnt_inc;
    logic [4:0]     src [2];
    logic [1:0]     src_hit;

    assign in_iter  = (state_reg == ITER);
    assign prd_nz   = |prd_reg;
    assign is_multi = (iss_kind == 2'd1) || (iss_kind == 2'd2);

    assign src[0] = rs1;
    assign src[1] = rs2;

    // Decode-source comparators against the pending destination.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = (src[gi] == prd_reg);
        end
    endgenerate

    assign stall_struct = in_iter & iss_vld & is_multi;
    assign haz_raw      = in_iter & prd_nz & (|src_hit);
    assign haz_waw      = in_iter & prd_nz & iss_vld & (iss_rd == prd_reg);

    // MUL behaves like IDLE for acceptance, so only ITER blocks a new op.
    assign accept   = iss_vld & rdy & is_multi & ~stall_struct & ~in_iter;
    assign acc_mul  = accept & (iss_kind == 2'd1);
    assign acc_iter = accept & (iss_kind == 2'd2);

    // Gated by reset so an abort clears the combinational outputs at once.
    assign start = ~reset & accept;
    assign stall = ~reset & (acc_mul | stall_struct | haz_raw | haz_waw);

    assign done    = cmpl | cmpl_pend_reg;
    assign cnt_inc = cnt_reg + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            prd_reg       <= 5'd0;
            cnt_reg       <= '0;
            cmpl_pend_reg <= 1'b0;
            wb_we_reg     <= 1'b0;
            wb_rd_reg     <= 5'd0;
            tmo_err_reg   <= 1'b0;
        end else begin
            wb_we_reg <= 1'b0;
            if (!rdy) begin
                // A completion arriving while frozen is remembered, not lost.
                if (in_iter && cmpl) begin
                    cmpl_pend_reg <= 1'b1;
                end
            end else begin
                case (state_reg)
                    IDLE, MUL: begin
                        if (acc_mul) begin
                            state_reg <= MUL;
                        end else if (acc_iter) begin
                            state_reg     <= ITER;
                            prd_reg       <= iss_rd;
                            cnt_reg       <= '0;
                            cmpl_pend_reg <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                    ITER: begin
                        if (done) begin
                            wb_we_reg     <= prd_nz;
                            wb_rd_reg     <= prd_reg;
                            cmpl_pend_reg <= 1'b0;
                            state_reg     <= IDLE;
                        end else begin
                            cnt_reg <= cnt_inc;
                            if (cnt_inc == CW'(DIV_TMO)) begin
                                tmo_err_reg <= 1'b1;
                                state_reg   <= IDLE;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign wb_we   = wb_we_reg;
    assign wb_rd   = wb_rd_reg;
    assign busy    = (state_reg != IDLE);
    assign tmo_err = tmo_err_reg;

endmodule

// File: tb/tb_rv_mcop_ctl.sv
// Bench for rv_mcop_ctl: directed scenarios with fixed expectations plus a
// randomized run against a behavioural model of the controller.
module tb_rv_mcop_ctl;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rdy = 1'b1;
    logic       iss_vld = 1'b0;
    logic [1:0] iss_kind = 2'd0;
    logic [4:0] iss_rd = 5'd0;
    logic [4:0] rs1 = 5'd0;
    logic [4:0] rs2 = 5'd0;
    logic       cmpl = 1'b0;

    logic       start, stall, wb_we, busy, tmo_err;
    logic [4:0] wb_rd;
    logic       t_start, t_stall, t_wb_we, t_busy, t_tmo_err;
    logic [4:0] t_wb_rd;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rv_mcop_ctl #(.DIV_TMO(TMO)) u_dut (
        .clk(clk), .reset(reset), .rdy(rdy), .iss_vld(iss_vld), .iss_kind(iss_kind),
        .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2), .cmpl(cmpl),
        .start(start), .stall(stall), .wb_we(wb_we), .wb_rd(wb_rd),
        .busy(busy), .tmo_err(tmo_err)
    );

    rv_mcop_ctl #(.DIV_TMO(4)) u_tmo (
        .clk(clk), .reset(reset), .rdy(rdy), .iss_vld(iss_vld), .iss_kind(iss_kind),
        .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2), .cmpl(cmpl),
        .start(t_start), .stall(t_stall), .wb_we(t_wb_we), .wb_rd(t_wb_rd),
        .busy(t_busy), .tmo_err(t_tmo_err)
    );

    // Behavioural model: an outstanding op is either a mul (one cycle) or an
    // iterative op with a pending rd, a wait count and a remembered completion.
    logic       m_iter = 1'b0, m_mul = 1'b0, m_cpend = 1'b0, m_we = 1'b0, m_tmo = 1'b0;
    logic [4:0] m_prd = 5'd0, m_wrd = 5'd0;
    int         m_wait = 0;
    logic       e_start, e_stall;

    always_comb begin
        e_start = 1'b0;
        e_stall = 1'b0;
        if (!reset) begin
            if (m_iter) begin
                e_stall = (iss_vld && (iss_kind == 2'd1 || iss_kind == 2'd2))
                       || (m_prd != 5'd0 && (rs1 == m_prd || rs2 == m_prd))
                       || (iss_vld && m_prd != 5'd0 && iss_rd == m_prd);
            end else begin
                e_start = iss_vld && rdy && (iss_kind == 2'd1 || iss_kind == 2'd2);
                e_stall = e_start && iss_kind == 2'd1;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_iter <= 1'b0; m_mul <= 1'b0; m_cpend <= 1'b0; m_we <= 1'b0;
            m_tmo <= 1'b0; m_prd <= 5'd0; m_wrd <= 5'd0; m_wait <= 0;
        end else begin
            m_we <= 1'b0;
            if (!rdy) begin
                if (m_iter && cmpl) m_cpend <= 1'b1;
            end else if (m_iter) begin
                if (cmpl || m_cpend) begin
                    m_we <= (m_prd != 5'd0);
                    m_wrd <= m_prd;
                    m_iter <= 1'b0;
                    m_cpend <= 1'b0;
                end else begin
                    m_wait <= m_wait + 1;
                    if (m_wait + 1 == TMO) begin
                        m_tmo <= 1'b1;
                        m_iter <= 1'b0;
                    end
                end
            end else begin
                m_mul <= iss_vld && iss_kind == 2'd1;
                if (iss_vld && iss_kind == 2'd2) begin
                    m_iter <= 1'b1; m_prd <= iss_rd; m_wait <= 0; m_cpend <= 1'b0;
                end
            end
        end
    end

    task automatic drv(input logic v, input logic [1:0] k, input logic [4:0] rd,
                       input logic [4:0] a, input logic [4:0] b, input logic c, input logic r);
        iss_vld = v; iss_kind = k; iss_rd = rd; rs1 = a; rs2 = b; cmpl = c; rdy = r;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        drv(0, 0, 0, 0, 0, 0, 1);
        reset = 1'b1;
        nxt();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drv(1, 1, 7, 0, 0, 0, 1);
        reset = 1'b1;
        mid();
        n_chk++;
        if ({start, stall, busy, wb_we, wb_rd, tmo_err} !== 10'd0)
            $display("FAIL reset_init: got %b expected 0", {start, stall, busy, wb_we, wb_rd, tmo_err});
        else n_pass++;
        nxt();
        reset = 1'b0;
        drv(1, 2, 5, 5, 0, 0, 1);
        mid();
        n_chk++;
        if ({start, stall} !== 2'b10) $display("FAIL reset_div_start: got %b expected 10", {start, stall});
        else n_pass++;
        nxt();
        for (int i = 0; i < 6; i++) begin
            drv(0, 0, 0, 5, 0, 0, 1);
            mid();
            if (i == 5) begin
                n_chk++;
                if ({stall, busy} !== 2'b11) $display("FAIL reset_pre_iter: got %b expected 11", {stall, busy});
                else n_pass++;
                #1 reset = 1'b1;
                #1;
                n_chk++;
                if ({start, stall, busy, wb_we, wb_rd, tmo_err} !== 10'd0)
                    $display("FAIL reset_mid_iter: got %b expected 0", {start, stall, busy, wb_we, wb_rd, tmo_err});
                else n_pass++;
            end
            nxt();
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 5, 0, 1, 1);
            mid();
            n_chk++;
            if ({wb_we, stall, busy} !== 3'b000) $display("FAIL reset_no_wb: got %b expected 000", {wb_we, stall, busy});
            else n_pass++;
            nxt();
        end
        $display("test_reset done");
    endtask

    task automatic test_mul();
        drv(1, 1, 7, 0, 0, 0, 0);
        mid();
        n_chk++;
        if ({start, stall} !== 2'b00) $display("FAIL mul_rdy0: got %b expected 00", {start, stall});
        else n_pass++;
        nxt();
        drv(1, 1, 7, 0, 0, 0, 1);
        mid();
        n_chk++;
        if ({start, stall, busy} !== 3'b110) $display("FAIL mul_accept: got %b expected 110", {start, stall, busy});
        else n_pass++;
        nxt();
        drv(0, 0, 0, 0, 0, 0, 1);
        mid();
        n_chk++;
        if ({start, stall, busy} !== 3'b001) $display("FAIL mul_state: got %b expected 001", {start, stall, busy});
        else n_pass++;
        nxt();
        mid();
        n_chk++;
        if (busy !== 1'b0) $display("FAIL mul_idle: got %b expected 0", busy);
        else n_pass++;
        nxt();
        $display("test_mul done");
    endtask

    task automatic test_div_raw();
        drv(1, 2, 5, 5, 0, 0, 1);
        mid();
        n_chk++;
        if ({start, stall} !== 2'b10) $display("FAIL raw_start: got %b expected 10", {start, stall});
        else n_pass++;
        nxt();
        for (int c = 1; c <= 14; c++) begin
            drv(0, 0, 0, 5, 0, (c == 12), 1);
            mid();
            n_chk++;
            if (c <= 12) begin
                if ({stall, wb_we} !== 2'b10) $display("FAIL raw_stall c%0d: got %b expected 10", c, {stall, wb_we});
                else n_pass++;
            end else if (c == 13) begin
                if ({stall, busy, wb_we, wb_rd} !== {3'b001, 5'd5})
                    $display("FAIL raw_wb: got %b expected %b", {stall, busy, wb_we, wb_rd}, {3'b001, 5'd5});
                else n_pass++;
            end else begin
                if (wb_we !== 1'b0) $display("FAIL raw_wb_pulse: got %b expected 0", wb_we);
                else n_pass++;
            end
            nxt();
        end
        $display("test_div_raw done");
    endtask

    task automatic test_back_to_back();
        drv(1, 2, 3, 0, 0, 0, 1);
        mid();
        n_chk++;
        if (start !== 1'b1) $display("FAIL b2b_start1: got %b expected 1", start);
        else n_pass++;
        nxt();
        for (int c = 1; c <= 4; c++) begin
            drv(1, 2, 9, 0, 0, (c == 4), 1);
            mid();
            n_chk++;
            if ({start, stall} !== 2'b01) $display("FAIL b2b_struct c%0d: got %b expected 01", c, {start, stall});
            else n_pass++;
            nxt();
        end
        drv(1, 2, 9, 0, 0, 0, 1);
        mid();
        n_chk++;
        if ({start, stall, wb_we, wb_rd} !== {3'b101, 5'd3})
            $display("FAIL b2b_restart: got %b expected %b", {start, stall, wb_we, wb_rd}, {3'b101, 5'd3});
        else n_pass++;
        nxt();
        drv(0, 0, 0, 0, 0, 0, 1);
        mid();
        n_chk++;
        if ({busy, wb_we} !== 2'b10) $display("FAIL b2b_iter2: got %b expected 10", {busy, wb_we});
        else n_pass++;
        nxt();
        drv(0, 0, 0, 0, 0, 1, 1);
        nxt();
        drv(0, 0, 0, 0, 0, 0, 1);
        mid();
        n_chk++;
        if ({wb_we, wb_rd} !== {1'b1, 5'd9}) $display("FAIL b2b_wb2: got %b expected %b", {wb_we, wb_rd}, {1'b1, 5'd9});
        else n_pass++;
        nxt();
        $display("test_back_to_back done");
    endtask

    task automatic test_timeout();
        pulse_reset();
        drv(1, 2, 6, 0, 0, 0, 1);
        mid();
        n_chk++;
        if ({t_start, t_stall} !== 2'b10) $display("FAIL tmo_start: got %b expected 10", {t_start, t_stall});
        else n_pass++;
        nxt();
        for (int c = 1; c <= 8; c++) begin
            drv(0, 0, 0, 0, 0, 0, 1);
            mid();
            n_chk++;
            if (c <= 4) begin
                if ({t_busy, t_tmo_err} !== 2'b10) $display("FAIL tmo_wait c%0d: got %b expected 10", c, {t_busy, t_tmo_err});
                else n_pass++;
            end else begin
                if ({t_busy, t_tmo_err, t_wb_we, busy, tmo_err} !== 5'b01010)
                    $display("FAIL tmo_sticky c%0d: got %b expected 01010", c, {t_busy, t_tmo_err, t_wb_we, busy, tmo_err});
                else n_pass++;
            end
            nxt();
        end
        drv(0, 0, 0, 0, 0, 1, 1);
        nxt();
        drv(0, 0, 0, 0, 0, 0, 1);
        nxt();
        $display("test_timeout done");
    endtask

    task automatic test_x0_freeze();
        pulse_reset();
        drv(1, 2, 0, 0, 0, 0, 1);
        nxt();
        for (int c = 1; c <= 4; c++) begin
            drv((c < 3), 0, 0, 0, 0, (c == 3), 1);
            mid();
            n_chk++;
            if (c < 4) begin
                if ({stall, busy} !== 2'b01) $display("FAIL x0_nostall c%0d: got %b expected 01", c, {stall, busy});
                else n_pass++;
            end else begin
                if ({wb_we, busy} !== 2'b00) $display("FAIL x0_nowb: got %b expected 00", {wb_we, busy});
                else n_pass++;
            end
            nxt();
        end
        drv(1, 2, 12, 0, 0, 0, 1);
        nxt();
        for (int c = 1; c <= 7; c++) begin
            drv(0, 0, 0, 0, 0, (c == 4), !(c >= 3 && c <= 5));
            mid();
            n_chk++;
            if (c <= 6) begin
                if ({busy, wb_we, t_busy, t_tmo_err} !== 4'b1010)
                    $display("FAIL frz_hold c%0d: got %b expected 1010", c, {busy, wb_we, t_busy, t_tmo_err});
                else n_pass++;
            end else begin
                if ({busy, wb_we, wb_rd, t_wb_we, t_wb_rd, t_tmo_err} !== {2'b01, 5'd12, 1'b1, 5'd12, 1'b0})
                    $display("FAIL frz_wb: got %b expected %b", {busy, wb_we, wb_rd, t_wb_we, t_wb_rd, t_tmo_err},
                             {2'b01, 5'd12, 1'b1, 5'd12, 1'b0});
                else n_pass++;
            end
            nxt();
        end
        $display("test_x0_freeze done");
    endtask

    task automatic test_random();
        pulse_reset();
        for (int i = 0; i < 1500; i++) begin
            drv(1'($urandom_range(0, 1)), 2'($urandom), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) != 0));
            mid();
            n_chk++;
            if ({start, stall, busy, wb_we, wb_rd, tmo_err} !== {e_start, e_stall, m_iter | m_mul, m_we, m_wrd, m_tmo})
                $display("FAIL rand cyc%0d: got %b expected %b", i, {start, stall, busy, wb_we, wb_rd, tmo_err},
                         {e_start, e_stall, m_iter | m_mul, m_we, m_wrd, m_tmo});
            else n_pass++;
            nxt();
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div_raw();
        test_back_to_back();
        test_timeout();
        test_x0_freeze();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
